// File: rtl/regfile_sb_if.sv
// Read, writeback and issue signals of the scoreboarded register file.
// The master side drives addresses and strobes. The slave side returns data, busy flags and ready.
interface regfile_sb_if #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRD  = 2
);
  localparam int AW = $clog2(NREG);

  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic                wr_en;
  logic [AW-1:0]       wr_addr;
  logic [XLEN-1:0]     wr_data;
  logic                iss_en;
  logic [AW-1:0]       iss_addr;
  logic                ready;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
    input  rd_data, rd_busy, ready
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
    output rd_data, rd_busy, ready
  );
endinterface

// File: rtl/regfile_sb.sv
// Multi-port register file with an x0-hardwired-zero rule, writeback bypass and a pending scoreboard.
// After reset, a sweep writes zero to every register before the block reports ready.
module regfile_sb #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRD  = 2
) (
  input  logic         clk,
  input  logic         rst,
  regfile_sb_if.slave  bus
);
  localparam int AW = $clog2(NREG);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t          state;
  logic [AW-1:0]   idx;
  logic            ready_q;
  logic [NREG-1:0] sb;
  logic [XLEN-1:0] regs [NREG];

  logic run, wr_hit, iss_hit;
  assign run     = (state == RUN);
  assign wr_hit  = run && bus.wr_en  && (bus.wr_addr  != '0);
  assign iss_hit = run && bus.iss_en && (bus.iss_addr != '0);

  // The sweep starts at 1 because x0 is never stored and always reads as zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      idx     <= AW'(1);
      ready_q <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          if (idx == AW'(NREG - 1)) begin
            state   <= RUN;
            ready_q <= 1'b1;
          end else begin
            idx <= idx + AW'(1);
          end
        end
        RUN: ;
        default: state <= CLEAR;
      endcase
    end
  end

  // The issue assignment comes last, so an issue to the same register wins over a writeback clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      sb <= '0;
    end else begin
      if (wr_hit)  sb[bus.wr_addr]  <= 1'b0;
      if (iss_hit) sb[bus.iss_addr] <= 1'b1;
    end
  end

  // NOTE: the storage array has no reset branch. The CLEAR sweep zeroes it instead, which keeps reset off a large flop array.
  always_ff @(posedge clk) begin
    if (state == CLEAR)
      regs[idx] <= '0;
    else if (wr_hit)
      regs[bus.wr_addr] <= bus.wr_data;
  end

  for (genvar i = 0; i < NRD; i++) begin : g_port
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] stored;
    logic            byp;

    assign addr   = bus.rd_addr[i*AW +: AW];
    assign stored = (addr == '0) ? '0 : regs[addr];
    assign byp    = wr_hit && (bus.wr_addr == addr);

    assign bus.rd_data[i*XLEN +: XLEN] = !run ? '0 : (byp ? bus.wr_data : stored);
    assign bus.rd_busy[i] = run && sb[addr] && !(bus.wr_en && (bus.wr_addr == addr));
  end

  assign bus.ready = ready_q;
endmodule
